// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue/writeback stage that sits directly in front of the
// 8-bit ALU. It accepts one 16-bit instruction per handshake and reads the
// operands from a 4x8 register file. It drives the ALU inputs for two cycles
// (ISSUE and WB), writes the ALU result (or an LDI immediate) back into the
// register file, and then holds a completion record until the consumer takes it.
//
// Instruction word: [15:13] opcode, [12:11] fcode, [10:9] rd, [8:7] ra,
//                   [6:5] rb, [7:0] imm (LDI only).
//
// Ports:
//   Clk, Reset_n                   clock, synchronous active-low reset
//   InstrValid/InstrReady/Instr    instruction handshake (ready only in IDLE)
//   AluA/AluB/AluOpcode/
//   AluFunctionCode/AluEnable      registered ALU request
//   AluO/AluOverflow               ALU result, sampled at the end of WB
//   ResultValid/ResultReady        completion record handshake
//   ResultData/ResultRd/
//   ResultCarry/ResultIllegal      completion record fields
//   StickyCarry                    OR of every ResultCarry since reset
//   DbgSel/DbgData                 combinational register file read port
module alu_issue_stage #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8   // must match the ALU width and the 8-bit immediate
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [15:0]       Instr,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic [2:0]        AluOpcode,
  output logic [1:0]        AluFunctionCode,
  output logic              AluEnable,
  input  logic [DATA_W-1:0] AluO,
  input  logic              AluOverflow,
  output logic              ResultValid,
  input  logic              ResultReady,
  output logic [DATA_W-1:0] ResultData,
  output logic [1:0]        ResultRd,
  output logic              ResultCarry,
  output logic              ResultIllegal,
  output logic              StickyCarry,
  input  logic [1:0]        DbgSel,
  output logic [DATA_W-1:0] DbgData
);

  localparam logic [2:0] OP_ARITH = 3'b000;
  localparam logic [2:0] OP_LOGIC = 3'b001;
  localparam logic [2:0] OP_LDI   = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB, S_DONE} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [1:0]        fc;
    logic              en;
  } alu_req_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [1:0]        rd;
    logic              carry;
    logic              illegal;
  } result_t;

  state_e                             state_q, state_d;
  logic [15:0]                        instr_q, instr_d;
  alu_req_t                           alu_q, alu_d;
  result_t                            res_q, res_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic                               sticky_q, sticky_d;

  // Arithmetic ops with fcode 10/11 are undefined, every logic fcode is valid.
  function automatic logic is_alu_op(input logic [2:0] op, input logic [1:0] fc);
    return ((op == OP_ARITH) && !fc[1]) || (op == OP_LOGIC);
  endfunction

  logic [2:0] wb_op;
  logic [1:0] wb_fc;
  logic [1:0] wb_rd;
  assign wb_op = instr_q[15:13];
  assign wb_fc = instr_q[12:11];
  assign wb_rd = instr_q[10:9];

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_d    = alu_q;
    res_d    = res_q;
    regs_d   = regs_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (InstrValid) begin
          instr_d = Instr;
          state_d = S_ISSUE;
          alu_d   = '0;
          // Operands are read here, before any write of this op, so rd==ra/rb
          // needs no forwarding. Non-ALU ops leave the ALU inputs at zero.
          if (is_alu_op(Instr[15:13], Instr[12:11])) begin
            alu_d.a  = regs_q[Instr[8:7]];
            alu_d.b  = regs_q[Instr[6:5]];
            alu_d.op = Instr[15:13];
            alu_d.fc = Instr[12:11];
            alu_d.en = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WB;
      S_WB: begin
        state_d       = S_DONE;
        alu_d         = '0;
        res_d.valid   = 1'b1;
        res_d.rd      = wb_rd;
        res_d.data    = '0;
        res_d.carry   = 1'b0;
        res_d.illegal = 1'b0;
        if (is_alu_op(wb_op, wb_fc)) begin
          regs_d[wb_rd] = AluO;
          res_d.data    = AluO;
          // Logic ops may drive junk on Overflow; only arithmetic carries.
          res_d.carry   = (wb_op == OP_ARITH) && AluOverflow;
        end else if (wb_op == OP_LDI) begin
          regs_d[wb_rd] = instr_q[DATA_W-1:0];
          res_d.data    = instr_q[DATA_W-1:0];
        end else begin
          res_d.illegal = 1'b1;
        end
        sticky_d = sticky_q | res_d.carry;
      end
      S_DONE: begin
        if (ResultReady) begin
          res_d.valid = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      alu_q    <= '0;
      res_q    <= '0;
      regs_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_q    <= alu_d;
      res_q    <= res_d;
      regs_q   <= regs_d;
      sticky_q <= sticky_d;
    end
  end

  // Ready only in IDLE: the cycle that accepts ResultReady is still DONE,
  // which yields the one-cycle bubble before the next accept.
  assign InstrReady      = (state_q == S_IDLE);
  assign AluA            = alu_q.a;
  assign AluB            = alu_q.b;
  assign AluOpcode       = alu_q.op;
  assign AluFunctionCode = alu_q.fc;
  assign AluEnable       = alu_q.en;
  assign ResultValid     = res_q.valid;
  assign ResultData      = res_q.data;
  assign ResultRd        = res_q.rd;
  assign ResultCarry     = res_q.carry;
  assign ResultIllegal   = res_q.illegal;
  assign StickyCarry     = sticky_q;
  assign DbgData         = regs_q[DbgSel];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed sequence plus randomized
// instructions, checked against an architectural register-file model.
module tb_alu_issue_stage;

  logic       Clk = 1'b0;
  logic       Reset_n, InstrValid, InstrReady, ResultReady;
  logic [15:0] Instr;
  logic [7:0] AluA, AluB, AluO, ResultData, DbgData;
  logic [2:0] AluOpcode;
  logic [1:0] AluFunctionCode, ResultRd, DbgSel;
  logic       AluEnable, AluOverflow, ResultValid, ResultCarry, ResultIllegal, StickyCarry;

  always #5 Clk = ~Clk;

  alu_issue_stage #(.NUM_REGS(4), .DATA_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .AluA(AluA), .AluB(AluB), .AluOpcode(AluOpcode),
    .AluFunctionCode(AluFunctionCode), .AluEnable(AluEnable),
    .AluO(AluO), .AluOverflow(AluOverflow),
    .ResultValid(ResultValid), .ResultReady(ResultReady),
    .ResultData(ResultData), .ResultRd(ResultRd), .ResultCarry(ResultCarry),
    .ResultIllegal(ResultIllegal), .StickyCarry(StickyCarry),
    .DbgSel(DbgSel), .DbgData(DbgData)
  );

  // Behavioural ALU. When disabled (or for logic-op overflow) it drives
  // changing junk so that any use of an undefined value shows up.
  logic [8:0] junk = 9'h0;
  logic [8:0] alu_s;
  always @(negedge Clk) junk <= 9'($urandom);
  always_comb begin
    alu_s = junk;
    if (AluEnable) begin
      case (AluOpcode)
        3'd0: alu_s = (AluFunctionCode == 2'd1) ? ({1'b0, AluA} + {1'b0, ~AluB} + 9'd1)
                                                : ({1'b0, AluA} + {1'b0, AluB});
        3'd1: case (AluFunctionCode)
                2'd0:    alu_s = {junk[8], AluA & AluB};
                2'd1:    alu_s = {junk[8], AluA | AluB};
                2'd2:    alu_s = {junk[8], AluA ^ AluB};
                default: alu_s = {junk[8], ~AluA};
              endcase
        default: ;
      endcase
    end
  end
  assign AluO        = alu_s[7:0];
  assign AluOverflow = alu_s[8];

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] ref_regs [4];
  logic       ref_sticky;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] fc,
                                     input logic [1:0] rd, input logic [1:0] ra,
                                     input logic [1:0] rb);
    return {op, fc, rd, ra, rb, 5'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b010, 2'b00, rd, 1'b0, imm};
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      DbgSel = 2'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), DbgData, ref_regs[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_sticky = 1'b0;
  endtask

  // One instruction end to end; 'hold' cycles of ResultReady=0 in DONE with
  // InstrValid asserted to prove it is ignored.
  task automatic run(input logic [15:0] ins, input int hold);
    logic [2:0] op;
    logic [1:0] fc, rd, ra, rb;
    logic [7:0] a, b, data;
    logic       en, carry, ill, wr;
    op = ins[15:13]; fc = ins[12:11]; rd = ins[10:9]; ra = ins[8:7]; rb = ins[6:5];
    a = ref_regs[ra]; b = ref_regs[rb];
    en = 1'b0; carry = 1'b0; ill = 1'b0; wr = 1'b1; data = 8'h00;
    if (op == 3'd0 && fc == 2'd0) begin
      en = 1'b1; data = 8'(a + b); carry = (int'(a) + int'(b)) > 255;
    end else if (op == 3'd0 && fc == 2'd1) begin
      en = 1'b1; data = 8'(a - b); carry = (a >= b);
    end else if (op == 3'd1) begin
      en = 1'b1;
      case (fc)
        2'd0: data = a & b;
        2'd1: data = a | b;
        2'd2: data = a ^ b;
        default: data = ~a;
      endcase
    end else if (op == 3'd2) begin
      data = ins[7:0];
    end else begin
      ill = 1'b1; wr = 1'b0;
    end

    chk("idle_rdy", InstrReady, 1'b1);
    Instr = ins; InstrValid = 1'b1; DbgSel = rd;
    step();                                   // accept edge N -> ISSUE
    InstrValid = 1'b0; Instr = 16'($urandom);
    chk("iss_en", AluEnable, en);
    chk("iss_a", AluA, en ? a : 8'h00);
    chk("iss_b", AluB, en ? b : 8'h00);
    chk("iss_op", AluOpcode, en ? op : 3'd0);
    chk("iss_fc", AluFunctionCode, en ? fc : 2'd0);
    chk("iss_rv", ResultValid, 1'b0);
    chk("iss_rdy", InstrReady, 1'b0);
    step();                                   // edge N+1 -> WB
    chk("wb_en", AluEnable, en);
    chk("wb_rv", ResultValid, 1'b0);
    step();                                   // edge N+2 -> DONE, write
    if (wr) ref_regs[rd] = data;
    ref_sticky = ref_sticky | carry;
    chk("done_rv", ResultValid, 1'b1);
    chk("done_data", ResultData, data);
    chk("done_rd", ResultRd, rd);
    chk("done_carry", ResultCarry, carry);
    chk("done_ill", ResultIllegal, ill);
    chk("done_sticky", StickyCarry, ref_sticky);
    chk("done_dbg", DbgData, ref_regs[rd]);
    chk("done_en", AluEnable, 1'b0);
    chk("done_rdy", InstrReady, 1'b0);
    for (int i = 0; i < hold; i++) begin
      InstrValid = 1'b1; Instr = 16'($urandom);
      step();
      chk("hold_rv", ResultValid, 1'b1);
      chk("hold_data", ResultData, data);
      chk("hold_carry", ResultCarry, carry);
      chk("hold_ill", ResultIllegal, ill);
      chk("hold_rdy", InstrReady, 1'b0);
    end
    InstrValid = 1'b0; ResultReady = 1'b1;
    step();                                   // DONE -> IDLE
    ResultReady = 1'b0;
    chk("rel_rv", ResultValid, 1'b0);
    chk("rel_rdy", InstrReady, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    int         r;
    Reset_n = 1'b0; InstrValid = 1'b0; ResultReady = 1'b0; DbgSel = 2'd0; Instr = 16'h0;
    model_reset();
    step(); step();
    Reset_n = 1'b1;
    chk("rst_rdy", InstrReady, 1'b1);
    chk("rst_rv", ResultValid, 1'b0);
    chk("rst_en", AluEnable, 1'b0);
    chk("rst_sticky", StickyCarry, 1'b0);
    chk("rst_data", ResultData, 8'h00);
    chk("rst_alua", AluA, 8'h00);
    check_regs();

    run(ldi(2'd1, 8'hF0), 0);
    run(ldi(2'd2, 8'h20), 0);
    DbgSel = 2'd1; #1; chk("ldi_r1", DbgData, 8'hF0);
    run(mk(3'd0, 2'd0, 2'd3, 2'd1, 2'd2), 0);         // ADD r3 = r1 + r2
    DbgSel = 2'd3; #1; chk("add_r3", DbgData, 8'h10);
    chk("add_sticky", StickyCarry, 1'b1);
    run(mk(3'd0, 2'd1, 2'd0, 2'd2, 2'd1), 0);         // SUB r0 = r2 - r1
    DbgSel = 2'd0; #1; chk("sub_r0", DbgData, 8'h30);
    run(mk(3'd1, 2'd2, 2'd0, 2'd1, 2'd2), 0);         // XOR r0 = r1 ^ r2
    DbgSel = 2'd0; #1; chk("xor_r0", DbgData, 8'hD0);
    run(mk(3'd1, 2'd3, 2'd0, 2'd1, 2'd2), 0);         // NOT r0 = ~r1
    DbgSel = 2'd0; #1; chk("not_r0", DbgData, 8'h0F);
    run(mk(3'd5, 2'd0, 2'd2, 2'd1, 2'd2), 0);         // illegal opcode
    run(mk(3'd0, 2'd3, 2'd1, 2'd1, 2'd2), 0);         // illegal fcode
    check_regs();
    run(mk(3'd1, 2'd0, 2'd3, 2'd1, 2'd2), 5);         // backpressure

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      op = 3'd0;
      else if (r < 6) op = 3'd1;
      else if (r < 8) op = 3'd2;
      else            op = 3'($urandom_range(3, 7));
      if (op == 3'd2) run(ldi(2'($urandom), 8'($urandom)), int'($urandom_range(0, 3)));
      else run(mk(op, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)),
               int'($urandom_range(0, 3)));
    end
    check_regs();

    // Reset during ISSUE of ADD r3 aborts the op.
    run(ldi(2'd3, 8'h77), 0);
    Instr = mk(3'd0, 2'd0, 2'd3, 2'd1, 2'd2); InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    chk("abort_iss_en", AluEnable, 1'b1);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    model_reset();
    chk("abort_en", AluEnable, 1'b0);
    chk("abort_rv", ResultValid, 1'b0);
    chk("abort_sticky", StickyCarry, 1'b0);
    chk("abort_rdy", InstrReady, 1'b1);
    step(); step();
    chk("abort_rv2", ResultValid, 1'b0);
    DbgSel = 2'd3; #1; chk("abort_r3", DbgData, 8'h00);
    check_regs();
    run(ldi(2'd0, 8'h5A), 1);
    check_regs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Issue/writeback stage directly upstream of the 8-bit ALU. It accepts one 16-bit instruction per handshake and reads two operands from a 4x8 register file. It drives the ALU's A/B/Opcode/FunctionCode/Enable inputs, captures the ALU's O/Overflow result into the destination register, and returns a completion record to the sequencer over a valid/ready handshake.

Parameters:
- NUM_REGS, 4, register file depth (fixed at 4; register indices are 2 bits).
- DATA_W, 8, operand/result width (must equal the ALU width).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- InstrValid  in  1  instruction word presented.
- InstrReady  out  1  stage can accept an instruction (IDLE only).
- Instr  in  16  [15:13]=opcode, [12:11]=fcode, [10:9]=rd, [8:7]=ra, [6:5]=rb, [7:0]=imm (LDI only).
- AluA  out  8  ALU operand A.
- AluB  out  8  ALU operand B.
- AluOpcode  out  3  ALU opcode.
- AluFunctionCode  out  2  ALU function code.
- AluEnable  out  1  ALU enable.
- AluO  in  8  ALU result.
- AluOverflow  in  1  ALU carry/overflow bit.
- ResultValid  out  1  completion record valid.
- ResultReady  in  1  consumer accepts the completion record.
- ResultData  out  8  value written to rd (0 if illegal).
- ResultRd  out  2  destination index.
- ResultCarry  out  1  ALU Overflow for this op (0 for logic/LDI/illegal).
- ResultIllegal  out  1  instruction was illegal; no write occurred.
- StickyCarry  out  1  OR of all ResultCarry since reset.
- DbgSel  in  2  debug read index.
- DbgData  out  8  combinational read of reg[DbgSel].

Behaviour:
- Reset (Reset_n=0 at a rising edge): all regs, state, and outputs go to 0; state=IDLE; any in-flight op is aborted with no write and no ResultValid.
- States: IDLE -> ISSUE -> WB -> DONE -> IDLE.
- IDLE:
  - InstrReady=1, AluEnable=0.
  - On InstrValid&&InstrReady, latch Instr and go to ISSUE.
- ISSUE (1 cycle):
  - AluA=reg[ra], AluB=reg[rb], AluOpcode=opcode, AluFunctionCode=fcode, AluEnable=1; all registered outputs.
  - AluEnable=1 only for legal ALU ops (opcode 000 with fcode 00/01; opcode 001 with any fcode); else AluEnable=0 and ALU inputs are 0.
  - Next state is WB.
- WB (1 cycle):
  - Sample AluO/AluOverflow; AluEnable stays 1 through this cycle and drops on exit.
  - Legal ALU op: reg[rd]<=AluO; ResultData=AluO; ResultCarry=AluOverflow for opcode 000, 0 for opcode 001.
  - Opcode 010 (LDI): reg[rd]<=imm; ResultCarry=0; the ALU is not enabled.
  - Illegal (opcode 011-111, or opcode 000 with fcode 10/11): no write, ResultData=0, ResultIllegal=1.
  - StickyCarry|=ResultCarry. Next state is DONE.
- DONE:
  - ResultValid=1; the record is held stable until ResultReady.
  - On ResultReady, go to IDLE.
  - InstrReady is never 1 in the same cycle as the accepting ResultReady, which gives one bubble.
- Latency: accept at edge N, register write at edge N+2, ResultValid visible after edge N+2. Minimum throughput is 1 instruction per 4 cycles.
- Hazards: rd==ra/rb needs no special handling; reads occur in ISSUE, before the WB write.
- Arithmetic: fcode 01 is subtraction (A+~B+1); its carry=1 means no borrow. The stage does not reinterpret it.
- DbgData reflects a write from the cycle after the WB edge.
- StickyCarry is cleared only by reset.

Test Plan:
- Reset, then LDI r1=0xF0 and LDI r2=0x20 -> DbgData(r1)=0xF0, ResultCarry=0, each ResultValid at accept+2 edges.
- ADD r3=r1+r2 (opcode 000, fcode 00) -> AluA=0xF0, AluB=0x20, AluEnable=1 in ISSUE; r3=0x10; ResultCarry=1; StickyCarry=1.
- SUB r0=r2-r1 (000/01) -> r0=0x30, ResultCarry=0. XOR r0=r1^r2 (001/10) -> r0=0xD0. NOT r0=~r1 (001/11) -> r0=0x0F.
- Opcode 101 and opcode 000/fcode 11 -> ResultIllegal=1, ResultData=0, AluEnable=0, destination register unchanged.
- Hold ResultReady=0 for 5 cycles -> ResultValid and record stable, InstrReady=0, a presented InstrValid is ignored; on release the stage returns to IDLE next cycle.
- Assert Reset_n=0 during ISSUE of ADD r3 -> r3=0, StickyCarry=0, no ResultValid, InstrReady=1 after release.
